// File: rtl/muldiv_if.sv
// Execute-stage bus for the muldiv unit: operation launch, MTHI/MTLO writes
// and the architectural HI/LO read-back.
interface muldiv_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  hi_we;
   logic                  lo_we;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the MIPS HI/LO registers.
// Define MULDIV_FAST_MUL_EN to run multiplies through a single-cycle multiplier.
module muldiv #(
   parameter int DATA_WIDTH = 32
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic [1:0]     op_q, op_d;
   logic           negq_q, negq_d;
   logic           negr_q, negr_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           opSigned;
   logic [W-1:0]   magA, magB;

   // Signed ops work on magnitudes; the sign is reapplied once in FIX.
   assign opSigned = ~bus.op[0];
   assign magA     = (opSigned && bus.a[W-1]) ? -bus.a : bus.a;
   assign magB     = (opSigned && bus.b[W-1]) ? -bus.b : bus.b;

   // acc = {upper, lower}: multiply keeps the multiplier in lower and shifts
   // the partial product in from the top; divide keeps {remainder, dividend/quotient}.
   logic [W:0]     mulSum;
   logic [W:0]     divShift;
   logic [W-1:0]   divDiff;
   logic           divGe;
   logic [2*W-1:0] mulStep, divStep;

   assign mulSum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mulStep  = {mulSum, acc_q[W-1:1]};
   assign divShift = {acc_q[2*W-1:W], acc_q[W-1]};
   assign divGe    = divShift >= {1'b0, opnd_q};
   assign divDiff  = divShift[W-1:0] - opnd_q;
   assign divStep  = {(divGe ? divDiff : divShift[W-1:0]), acc_q[W-2:0], divGe};

   logic [2*W-1:0] prodRes;
   logic [W-1:0]   quotRes, remRes;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] fastA, fastB;

   assign fastA   = op_q[0] ? {{W{1'b0}}, a_q} : {{W{a_q[W-1]}}, a_q};
   assign fastB   = op_q[0] ? {{W{1'b0}}, b_q} : {{W{b_q[W-1]}}, b_q};
   assign prodRes = fastA * fastB;
`else
   assign prodRes = negq_q ? -acc_q : acc_q;
`endif

   assign quotRes = negq_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
   assign remRes  = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

   // Next-state and datapath: launch in IDLE, one result bit per RUN cycle,
   // sign fix-up and HI/LO commit in FIX.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               a_d     = bus.a;
               b_d     = bus.b;
               negq_d  = opSigned & (bus.a[W-1] ^ bus.b[W-1]);
               negr_d  = opSigned & bus.a[W-1];
               cnt_d   = CW'(W);
               busy_d  = 1'b1;
               state_d = RUN;
               if (bus.op[1]) begin
                  opnd_d = magB;
                  acc_d  = {{W{1'b0}}, magA};
               end else begin
                  opnd_d = magA;
                  acc_d  = {{W{1'b0}}, magB};
               end
`ifdef MULDIV_FAST_MUL_EN
               if (!bus.op[1]) begin
                  state_d = FIX;
               end
`endif
            end else begin
               if (bus.hi_we) begin
                  hi_d = bus.wdata;
               end
               if (bus.lo_we) begin
                  lo_d = bus.wdata;
               end
            end
         end

         RUN: begin
            cnt_d = cnt_q - CW'(1);
            acc_d = op_q[1] ? divStep : mulStep;
            if (cnt_q == CW'(1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            if (!op_q[1]) begin
               {hi_d, lo_d} = prodRes;
            end else if (b_q == '0) begin
               hi_d = a_q;
               lo_d = '1;
            end else begin
               hi_d = remRes;
               lo_d = quotRes;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset abandons any in-flight operation and clears HI/LO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: directed corner cases plus random operations
// checked against plain integer arithmetic.
module tb_muldiv;
   localparam int W = 32;
   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef struct {
      logic [63:0] res;
      int          doneCycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   muldiv_if #(.DATA_WIDTH(W)) bus ();

   muldiv #(.DATA_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          tests      = 0;
   int          failures   = 0;
   int          cycle      = 0;
   int          issueCycle = 0;
   exp_t        expQ[$];
   exp_t        monE;
   logic [31:0] modelHi = '0;
   logic [31:0] modelLo = '0;
   logic [31:0] prevHi  = '0;
   logic [31:0] prevLo  = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference results straight from integer arithmetic and the MIPS rules.
   function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint      sp;
      int          sq, sr;
      logic [31:0] q32, r32;
      case (op)
         OP_MULT: begin
            sp = longint'(int'(a)) * longint'(int'(b));
            return sp;
         end
         OP_MULTU: return {32'd0, a} * {32'd0, b};
         OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
            sq  = int'(a) / int'(b);
            sr  = int'(a) % int'(b);
            q32 = sq;
            r32 = sr;
            return {r32, q32};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            q32 = a / b;
            r32 = a % b;
            return {r32, q32};
         end
      endcase
   endfunction

   function automatic int latency(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) return 1;
`endif
      return W + 1;
   endfunction

   // Issue one start pulse from a negedge and queue the expected result.
   task automatic issueOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] r;
      int          n = 0;
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      r          = refModel(op, a, b);
      bus.op     = op;
      bus.a      = a;
      bus.b      = b;
      bus.start  = 1'b1;
      issueCycle = cycle;
      e.res       = r;
      e.doneCycle = cycle + 1 + latency(op);
      expQ.push_back(e);
      prevHi  = modelHi;
      prevLo  = modelLo;
      modelHi = r[63:32];
      modelLo = r[31:0];
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("busy_after_start", 64'(bus.busy), 64'd1);
   endtask

   task automatic waitIdle(input int lat);
      int n     = 0;
      int moved = 0;
      while (bus.busy && n < 200) begin
         if (bus.hi !== prevHi || bus.lo !== prevLo) moved++;
         @(negedge clk);
         n++;
      end
      checkOutput("hilo_stable", 64'(moved), 64'd0);
      checkOutput("busy_len", 64'(cycle - issueCycle), 64'(lat + 1));
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      issueOp(op, a, b);
      waitIdle(latency(op));
   endtask

   task automatic writeHiLo(input logic hwe, input logic lwe, input logic [31:0] d);
      bus.hi_we = hwe;
      bus.lo_we = lwe;
      bus.wdata = d;
      @(negedge clk);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      if (hwe) modelHi = d;
      if (lwe) modelLo = d;
      checkOutput("mt_hi", 64'(bus.hi), 64'(modelHi));
      checkOutput("mt_lo", 64'(bus.lo), 64'(modelLo));
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (expQ.size() == 0) begin
            checkOutput("stale_done", 64'd1, 64'd0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("res_hi", 64'(bus.hi), 64'(monE.res[63:32]));
            checkOutput("res_lo", 64'(bus.lo), 64'(monE.res[31:0]));
            checkOutput("done_cycle", 64'(cycle), 64'(monE.doneCycle));
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 64'(bus.busy), 64'd0);
      checkOutput("reset_done", 64'(bus.done), 64'd0);
      checkOutput("reset_hi", 64'(bus.hi), 64'd0);
      checkOutput("reset_lo", 64'(bus.lo), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      applyStimulus(OP_MULT,  32'hFFFFFFFD, 32'd5);
      applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'd2);
      applyStimulus(OP_DIV,   32'h80000000, 32'hFFFFFFFF);
      applyStimulus(OP_DIVU,  32'd100,      32'd0);
      applyStimulus(OP_DIV,   32'hFFFFFF9C, 32'd0);
      applyStimulus(OP_MULT,  32'h80000000, 32'h80000000);
      writeHiLo(1'b1, 1'b1, 32'h5555AAAA);
      writeHiLo(1'b1, 1'b0, 32'h00C0FFEE);

      // A write in the same cycle as start loses to the start.
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'hDEADBEEF;
      issueOp(OP_MULTU, 32'd3, 32'd4);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      waitIdle(latency(OP_MULTU));

      // Start and MTHI while busy are both ignored.
      issueOp(OP_DIVU, 32'd7, 32'd3);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.a     = 32'd9;
      bus.b     = 32'd9;
      bus.hi_we = 1'b1;
      bus.wdata = 32'h1234;
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      waitIdle(latency(OP_DIVU));
      checkOutput("intf_hi", 64'(bus.hi), 64'd1);
      checkOutput("intf_lo", 64'(bus.lo), 64'd2);
      writeHiLo(1'b0, 1'b1, 32'hABCD);
      checkOutput("mtlo_hi_kept", 64'(bus.hi), 64'd1);

      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin
               ra = 32'h80000000;
               rb = 32'hFFFFFFFF;
            end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         applyStimulus(rop, ra, rb);
         if ($urandom_range(0, 3) == 0) begin
            writeHiLo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         end
      end

      // Asynchronous reset in the middle of a divide.
      issueOp(OP_DIV, 32'hFFFF0000, 32'd7);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
      checkOutput("midrst_done", 64'(bus.done), 64'd0);
      checkOutput("midrst_hi", 64'(bus.hi), 64'd0);
      checkOutput("midrst_lo", 64'(bus.lo), 64'd0);
      expQ.delete();
      modelHi = '0;
      modelLo = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      applyStimulus(OP_MULTU, 32'd6, 32'd7);
      checkOutput("post_rst_lo", 64'(bus.lo), 64'd42);
      checkOutput("post_rst_hi", 64'(bus.hi), 64'd0);

      repeat (W + 4) @(negedge clk);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits beside the combinational ALU in the execute stage and implements MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes. The core reads HI/LO for MFHI/MFLO and stalls while `busy` is high. The data width is parametrised and the unit computes one result bit per cycle.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width (W); must be >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation in `op`; sampled only when not busy.
- op  input  2  operation: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- a  input  W  multiplicand / dividend.
- b  input  W  multiplier / divisor.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  W  MTHI/MTLO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  W  HI register (remainder or product upper half).
- lo  output  W  LO register (quotient or product lower half).

Behaviour:
- Reset (asynchronous, at any time including mid-operation):
  - busy = 0, done = 0, hi = 0, lo = 0.
  - FSM goes to IDLE; any in-flight operation is discarded.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on start = 1.
    - Latch operand magnitudes: absolute values for MULT/DIV, raw values for MULTU/DIVU.
    - Latch result-sign flags and op.
    - Load iteration counter with W.
  - RUN performs one iteration per cycle and decrements the counter.
    - Multiply: shift-add, one multiplier bit per cycle into a 2W accumulator.
    - Divide: restoring division, one quotient bit per cycle.
  - RUN -> FIX on the edge where the counter reaches 0.
  - FIX applies sign correction, writes hi/lo, pulses done, then goes to IDLE.
- Timing: start sampled at edge E0.
  - busy = 1 from after E0 until after edge E(W+1).
  - hi/lo update and done = 1 occur after E(W+1).
  - A new start is accepted at E(W+1) + 1 cycle, i.e. total latency is W+1 cycles.
- busy is a registered output and is never asserted in the same cycle as start.
- start while busy is ignored and has no queuing effect.
- Sign rules:
  - Signed product = two's-complement 2W result {hi, lo}.
  - Signed quotient is negative iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Overflow: DIV of -2^(W-1) by -1 gives lo = -2^(W-1), hi = 0 (wrap; no trap).
- Divide by zero (DIV or DIVU, b = 0): hi = a (raw), lo = all ones. Same latency; done still pulses.
- MTHI/MTLO:
  - hi_we/lo_we write wdata at the next edge, but only when not busy and start = 0.
  - If start and a write occur in the same cycle, start wins and the write is dropped.
  - A write asserted while busy is dropped.
  - hi_we and lo_we together write both registers.
- hi/lo are stable throughout RUN; they hold their previous values until FIX.
- done is high for exactly one cycle per accepted start and is 0 at all other times.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle W x W multiplier.
  - start at E0 -> hi/lo written and done = 1 after E1.
  - busy = 1 for exactly one cycle.
  - Divide latency is unchanged.
- Undefined:
  - All operations use the iterative W+1 cycle path.
  - No hardware multiplier is inferred.
- Results must be bit-identical in both builds.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly 33 cycles after start, or 1 cycle with MULDIV_FAST_MUL_EN.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, busy for 33 cycles.
- Interference during DIVU 7/3:
  - Assert start (op=MULTU) and hi_we with wdata=0x1234 at cycle 5 -> both ignored; final hi=1, lo=2.
  - After done, lo_we with wdata=0xABCD -> lo=0xABCD next cycle, hi unchanged.
- Reset mid-operation:
  - Assert rst at cycle 10 of a DIV -> busy=0, done=0, hi=lo=0 immediately (asynchronous).
  - After release, start MULTU 6*7 -> lo=42, hi=0, no stale done pulse.
